// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and
// frame-format encodings common to uart_rx and uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_e;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   localparam logic [1:0] STOP_1   = 2'b00;
   localparam logic [1:0] STOP_1P5 = 2'b01;
   localparam logic [1:0] STOP_2   = 2'b10;
   localparam logic [1:0] STOP_2B  = 2'b11;

   localparam logic PAR_ODD  = 1'b0;
   localparam logic PAR_EVEN = 1'b1;

   function automatic logic [3:0] data_bits(input logic [1:0] num);
      return 4'd5 + {2'b00, num};
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage bit synchroniser for asynchronous inputs.
// Resets to RST_VAL so an idle-high line reads as idle.
module uart_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // shift the async input through the flop chain
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync <= {STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled frame recovery with
// 5-8 data bits, optional parity and 1/1.5/2 stop bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_i,
   input  logic       rx_i,
   input  logic       parity_en_i,
   input  logic       parity_type_i,
   input  logic [1:0] data_bit_num_i,
   input  logic [1:0] stop_bit_num_i,
   output logic [7:0] data_o,
   output logic       active_flag,
   output logic       done_flag,
   output logic       parity_err_o,
   output logic       frame_err_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);

   rx_state_e     r_state;
   logic [TW-1:0] r_tick_cnt;
   logic [2:0]    r_bit_cnt;
   logic          r_stop_cnt;
   logic [7:0]    r_shift;
   logic          r_par_bit;
   logic          r_stop_err;
   logic          r_tick_d;
   logic          r_rx_d;
   logic          r_pen;
   logic          r_ptype;
   logic [3:0]    r_nbits;
   logic [1:0]    r_stop_num;

   logic          w_rx;
   logic          w_tick;
   logic          w_fall;
   logic          w_last_bit;
   logic          w_last_stop;
   logic [TW-1:0] w_stop_tc;
   logic          w_par_err;

   uart_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (rx_i),
      .o_q     (w_rx)
   );

   assign w_tick = tick_i & ~r_tick_d;
   assign w_fall = r_rx_d & ~w_rx;

   assign w_last_bit = ({1'b0, r_bit_cnt} == (r_nbits - 4'd1));

   // second half-stop of a 1.5 stop frame is only half a bit long
   assign w_stop_tc = (r_stop_cnt && r_stop_num == STOP_1P5) ?
                      TC_HALF : TC_FULL;
   assign w_last_stop = r_stop_cnt | (r_stop_num == STOP_1);

   // r_shift only holds bits received, so unused MSBs stay zero
   assign w_par_err = r_pen &
                      ((^r_shift ^ r_par_bit) != ~r_ptype);

   // registered copies for tick and line edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tick_d <= 1'b0;
         r_rx_d   <= 1'b1;
      end else begin
         r_tick_d <= tick_i;
         r_rx_d   <= w_rx;
      end
   end

   // frame FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= RX_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= 1'b0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         r_stop_err   <= 1'b0;
         r_pen        <= 1'b0;
         r_ptype      <= 1'b0;
         r_nbits      <= 4'd5;
         r_stop_num   <= STOP_1;
         data_o       <= '0;
         active_flag  <= 1'b0;
         done_flag    <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         done_flag <= 1'b0;
         unique case (r_state)
            RX_IDLE: begin
               if (w_fall) begin
                  r_state    <= RX_START;
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_stop_cnt <= 1'b0;
                  r_shift    <= '0;
                  r_par_bit  <= 1'b0;
                  r_stop_err <= 1'b0;
                  r_pen      <= parity_en_i;
                  r_ptype    <= parity_type_i;
                  r_nbits    <= data_bits(data_bit_num_i);
                  r_stop_num <= stop_bit_num_i;
               end
            end
            RX_START: begin
               if (w_tick) begin
                  if (r_tick_cnt == TC_HALF) begin
                     r_tick_cnt <= '0;
                     if (!w_rx) begin
                        active_flag <= 1'b1;
                        r_state     <= RX_DATA;
                     end else begin
                        r_state <= RX_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (w_tick) begin
                  if (r_tick_cnt == TC_FULL) begin
                     r_tick_cnt         <= '0;
                     r_shift[r_bit_cnt] <= w_rx;
                     r_bit_cnt          <= r_bit_cnt + 3'd1;
                     if (w_last_bit) begin
                        r_state <= r_pen ? RX_PARITY : RX_STOP;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
            end
            RX_PARITY: begin
               if (w_tick) begin
                  if (r_tick_cnt == TC_FULL) begin
                     r_tick_cnt <= '0;
                     r_par_bit  <= w_rx;
                     r_state    <= RX_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (w_tick) begin
                  if (r_tick_cnt == w_stop_tc) begin
                     r_tick_cnt <= '0;
                     if (w_last_stop) begin
                        done_flag    <= 1'b1;
                        active_flag  <= 1'b0;
                        data_o       <= r_shift;
                        parity_err_o <= w_par_err;
                        frame_err_o  <= r_stop_err | ~w_rx;
                        r_state      <= w_rx ? RX_IDLE : RX_BREAK;
                     end else begin
                        r_stop_err <= ~w_rx;
                        r_stop_cnt <= 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
            end
            RX_BREAK: begin
               if (w_rx) begin
                  r_state <= RX_IDLE;
               end
            end
            default: begin
               r_state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule
